// File: rtl/sub_128bit_seq.sv
// sub_128bit_seq: 128-bit A - B using one shared 64-bit carry-select slice over two passes
// Ports: clk, rst (sync, active-high), start (sampled while idle), A/B (operands latched on accept),
//        busy (LOW/HIGH passes), done (one-cycle result pulse), Diff (A - B mod 2^128), Borrow (A < B).
// Optional macro SIGNED_OVF_EN adds Ovf, the two's-complement overflow of A - B.
module sub_128bit_seq #(
    parameter int SLICE_W = 64,
    parameter int WIDTH   = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
`ifdef SIGNED_OVF_EN
    output logic             Ovf,
`endif
    output logic             Borrow
);
    localparam int BLK = 16;
    localparam int NB  = SLICE_W / BLK;
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] r_a, r_b;
    logic carry;
    logic [SLICE_W-1:0] x, y, sum;
    logic cin, cout, cc;
    logic [BLK:0] s0 [NB];
    logic [BLK:0] s1 [NB];
    always_comb begin
        x   = state == HIGH ? r_a[WIDTH-1:SLICE_W] : r_a[SLICE_W-1:0];
        y   = state == HIGH ? r_b[WIDTH-1:SLICE_W] : r_b[SLICE_W-1:0];
        cin = state == HIGH ? carry : 1'b1;
    end
    // each block precomputes both carry-in outcomes; the ripple only drives muxes
    for (genvar g = 0; g < NB; g++) begin : g_blk
        assign s0[g] = {1'b0, x[g*BLK +: BLK]} + {1'b0, y[g*BLK +: BLK]};
        assign s1[g] = {1'b0, x[g*BLK +: BLK]} + {1'b0, y[g*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
    end
    always_comb begin
        sum = '0;
        cc  = cin;
        for (int i = 0; i < NB; i++) begin
            sum[i*BLK +: BLK] = cc ? s1[i][BLK-1:0] : s0[i][BLK-1:0];
            cc = cc ? s1[i][BLK] : s0[i][BLK];
        end
        cout = cc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            r_a    <= '0;
            r_b    <= '0;
            carry  <= 1'b0;
            Diff   <= '0;
            Borrow <= 1'b0;
`ifdef SIGNED_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                r_a <= A;
                r_b <= ~B;
            end
            if (state == LOW) begin
                Diff[SLICE_W-1:0] <= sum;
                carry             <= cout;
            end
            if (state == HIGH) begin
                Diff[WIDTH-1:SLICE_W] <= sum;
                Borrow                <= ~cout;
`ifdef SIGNED_OVF_EN
                // r_b holds ~B, so equal top bits means A and B had opposite signs
                Ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (sum[SLICE_W-1] != r_a[WIDTH-1]);
`endif
            end
        end
    end
    always_comb begin
        state_nx = state == IDLE ? (start ? LOW : IDLE) :
                   state == LOW  ? HIGH :
                   state == HIGH ? DONE : IDLE;
    end
    always_comb begin
        busy = state == LOW || state == HIGH;
        done = state == DONE;
    end
endmodule

// File: tb/tb_sub_128bit_seq.sv
// tb_sub_128bit_seq: directed bench for sub_128bit_seq with an operation-level reference model
module tb_sub_128bit_seq;
    logic clk = 0, rst = 1, start = 0;
    logic [127:0] A = '0, B = '0, Diff;
    logic busy, done, Borrow;
`ifdef SIGNED_OVF_EN
    logic Ovf;
`endif
    int total = 0, bad = 0, done_cnt = 0, cyc = 0, phase = 0;
    bit armed = 0;
    int done_cyc[$];
    logic [127:0] exp_d, last_d;
    logic exp_b, last_b, exp_o, last_o;

    sub_128bit_seq dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Diff(Diff),
`ifdef SIGNED_OVF_EN
        .Ovf(Ovf),
`endif
        .Borrow(Borrow)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, req, $time);
        end
    endfunction

    // operation-level model: an accepted request yields A - B three cycles later
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            phase = 0; armed = 1;
            last_d = '0; last_b = 0; last_o = 0;
        end else if (phase == 0) begin
            if (start) begin
                exp_d = A - B;
                exp_b = A < B;
                exp_o = (A[127] != B[127]) && (exp_d[127] != A[127]);
                phase = 1;
            end
        end else if (phase == 3) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == 3) begin
                last_d = exp_d; last_b = exp_b; last_o = exp_o;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", busy, phase == 1 || phase == 2);
            chk("done", done, phase == 3);
            if (phase != 2) begin
                chk("diff", Diff, last_d);
                chk("borrow", Borrow, last_b);
`ifdef SIGNED_OVF_EN
                chk("ovf", Ovf, last_o);
`endif
            end
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
        end
    end

    // call at #1 after a rising edge with the DUT idle
    task automatic op(input logic [127:0] a, input logic [127:0] b,
                      input logic [127:0] ed, input logic eb, input string nm);
        A = a; B = b; start = 1;
        @(posedge clk); #1;
        start = 0; A = {4{$urandom}}; B = {4{$urandom}};
        chk({nm, "_busy1"}, busy, 1);
        @(posedge clk); #1;
        chk({nm, "_busy2"}, busy, 1);
        @(posedge clk); #1;
        chk({nm, "_done"}, done, 1);
        chk({nm, "_nbusy"}, busy, 0);
        chk({nm, "_diff"}, Diff, ed);
        chk({nm, "_borrow"}, Borrow, eb);
        @(posedge clk); #1;
        chk({nm, "_done_end"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", Diff, 0);
        chk("rst_borrow", Borrow, 0);

        op(128'd100, 128'd58, 128'd42, 0, "basic");
        op(128'h1 << 64, 128'd1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 0, "chain");
        op(128'd0, 128'd1, {128{1'b1}}, 1, "wrap");

        A = 5; B = 3; start = 1;
        @(posedge clk); #1;
        A = 9; B = 9;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        chk("rej_done", done, 1);
        chk("rej_diff", Diff, 2);
        n = done_cnt;
        repeat (8) @(posedge clk);
        #1 chk("rej_single", done_cnt, n + 1);

        A = 10; B = 4; start = 1;
        @(posedge clk); #1;
        start = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_diff", Diff, 0);
        n = done_cnt;
        repeat (5) @(posedge clk);
        #1 chk("mid_rst_nodone", done_cnt, n);
        op(128'd7, 128'd7, 128'd0, 0, "equal");

        n = done_cnt;
        done_cyc.delete();
        for (int i = 0; i < 12; i++) begin
            start = 1;
            A = {$urandom, $urandom, $urandom, $urandom};
            B = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        start = 0;
        repeat (6) @(posedge clk);
        #1 chk("b2b_count", done_cnt, n + 3);
        if (done_cyc.size() == 3) begin
            chk("b2b_gap1", done_cyc[1] - done_cyc[0], 4);
            chk("b2b_gap2", done_cyc[2] - done_cyc[1], 4);
        end else
            chk("b2b_pulses", done_cyc.size(), 3);

`ifdef SIGNED_OVF_EN
        op({1'b0, {127{1'b1}}}, {128{1'b1}}, {1'b1, 127'd0}, 1, "ovf_pos");
        chk("ovf_set", Ovf, 1);
        op(128'd5, 128'd3, 128'd2, 0, "ovf_none");
        chk("ovf_clr", Ovf, 0);
`endif
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
